iserdes_word_align: RTL and testbench

//  Word-alignment controller directly downstream of the input deserializer, in the divided-clock domain.
//  - Consumes the deserializer's parallel word and compares it against a known training pattern.
//  - Issues single-cycle BITSLIP pulses back to the deserializer until the word lines up, then declares lock.
//  - Forwards the aligned word, registered, to the fabric.

---
 rtl/iserdes_align_pkg.sv | 15 +
 rtl/iserdes_align_match_cnt.sv | 44 ++++
 rtl/iserdes_word_align.sv | 165 ++++++++++++++++
 tb/tb_iserdes_word_align.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iserdes_align_pkg.sv
// Shared types and constants for the deserializer word-alignment controller.
package iserdes_align_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StSlip,
    StWait,
    StLock,
    StFail
  } align_state_e;

endpackage

// File: rtl/iserdes_align_match_cnt.sv
// Word compare against a fixed pattern feeding a saturating consecutive-event counter.
// With i_invert set the counted event is a mismatch instead of a match.
module iserdes_align_match_cnt
  import iserdes_align_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = '0,
  parameter int unsigned           THRESH     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_enable,
  input  logic                  i_invert,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_hit
);

  localparam logic [CNT_W-1:0] HIT_AT  = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_event;
  logic [CNT_W-1:0] r_count;

  assign w_event = (i_data == PATTERN) ^ i_invert;

  // Hit fires on the event that brings the run length up to THRESH.
  assign o_hit = i_enable & w_event & (r_count >= HIT_AT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (!w_event) begin
        r_count <= '0;
      end else if (r_count != CNT_MAX) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/iserdes_word_align.sv
// Bitslip-based word alignment against a training pattern, with registered data forwarding.
// Optional lock-loss monitor enabled by defining ISERDES_ALIGN_MONITOR_EN.
module iserdes_word_align
  import iserdes_align_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = 4,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 4'b0011,
  parameter int unsigned           MATCH_COUNT   = 4,
  parameter int unsigned           BITSLIP_GAP   = 3,
  parameter int unsigned           MAX_SLIPS     = 8,
  parameter int unsigned           LOSS_COUNT    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_train_en,
  input  logic [DATA_WIDTH-1:0] i_q,
  output logic                  o_bitslip,
  output logic                  o_locked,
  output logic                  o_error,
  output logic [CNT_W-1:0]      o_slip_cnt,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid
);

  localparam logic [CNT_W-1:0] SLIP_LIMIT = CNT_W'(MAX_SLIPS);
  localparam logic [2:0]       WAIT_LAST  = 3'(BITSLIP_GAP - 1);

  align_state_e          r_state, w_state_d;
  logic                  r_train_q;
  logic [CNT_W-1:0]      r_slip_cnt;
  logic [2:0]            r_wait_cnt;
  logic                  r_bitslip, r_locked, r_error, r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  logic w_rise, w_mismatch, w_lock_hit, w_loss_hit;
  logic w_slip_clr, w_slip_inc;

  assign w_rise     = i_train_en & ~r_train_q;
  assign w_mismatch = (i_q != TRAIN_PATTERN);

  iserdes_align_match_cnt #(
    .DATA_WIDTH (DATA_WIDTH),
    .PATTERN    (TRAIN_PATTERN),
    .THRESH     (MATCH_COUNT)
  ) u_lock_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (r_state != StCompare),
    .i_enable (r_state == StCompare),
    .i_invert (1'b0),
    .i_data   (i_q),
    .o_hit    (w_lock_hit)
  );

`ifdef ISERDES_ALIGN_MONITOR_EN
  logic w_mon_en;
  assign w_mon_en = (r_state == StLock) & i_train_en;

  iserdes_align_match_cnt #(
    .DATA_WIDTH (DATA_WIDTH),
    .PATTERN    (TRAIN_PATTERN),
    .THRESH     (LOSS_COUNT)
  ) u_loss_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (~w_mon_en),
    .i_enable (w_mon_en),
    .i_invert (1'b1),
    .i_data   (i_q),
    .o_hit    (w_loss_hit)
  );
`else
  logic [31:0] w_unused_loss_count;
  assign w_unused_loss_count = LOSS_COUNT;
  assign w_loss_hit          = 1'b0;
`endif

  always_comb begin
    w_state_d  = r_state;
    w_slip_clr = 1'b0;
    w_slip_inc = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_rise) begin
          w_state_d  = StCompare;
          w_slip_clr = 1'b1;
        end
      end
      StCompare: begin
        if (!i_train_en) begin
          w_state_d = StIdle;
        end else if (w_lock_hit) begin
          w_state_d = StLock;
        end else if (w_mismatch) begin
          if (r_slip_cnt == SLIP_LIMIT) begin
            w_state_d = StFail;
          end else begin
            w_state_d  = StSlip;
            w_slip_inc = 1'b1;
          end
        end
      end
      StSlip: begin
        w_state_d = i_train_en ? StWait : StIdle;
      end
      StWait: begin
        if (!i_train_en) begin
          w_state_d = StIdle;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_d = StCompare;
        end
      end
      StLock: begin
        if (w_rise || w_loss_hit) begin
          w_state_d  = StCompare;
          w_slip_clr = 1'b1;
        end
      end
      StFail: begin
        if (w_rise) begin
          w_state_d  = StCompare;
          w_slip_clr = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_train_q  <= 1'b0;
      r_slip_cnt <= '0;
      r_wait_cnt <= '0;
      r_bitslip  <= 1'b0;
      r_locked   <= 1'b0;
      r_error    <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_train_q <= i_train_en;
      if (w_slip_clr) begin
        r_slip_cnt <= '0;
      end else if (w_slip_inc && (r_slip_cnt != SLIP_LIMIT)) begin
        r_slip_cnt <= r_slip_cnt + 1'b1;
      end
      r_wait_cnt <= (r_state == StWait) ? r_wait_cnt + 3'd1 : 3'd0;
      // Status outputs are decoded from the next state so they change with it.
      r_bitslip  <= (w_state_d == StSlip);
      r_locked   <= (w_state_d == StLock);
      r_error    <= (w_state_d == StFail);
      r_data     <= i_q;
      r_valid    <= r_locked;
    end
  end

  assign o_bitslip    = r_bitslip;
  assign o_locked     = r_locked;
  assign o_error      = r_error;
  assign o_slip_cnt   = r_slip_cnt;
  assign o_data       = r_data;
  assign o_data_valid = r_valid;

endmodule

// File: tb/tb_iserdes_word_align.sv
// Bench for iserdes_word_align with a 4-bit rotating deserializer model.
module tb_iserdes_word_align;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       train_en;
  logic [3:0] q_in;
  logic       bitslip, locked, error, data_valid;
  logic [3:0] slip_cnt, data_out;

  int n_tests = 0;
  int n_fail  = 0;

  iserdes_word_align u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_train_en   (train_en),
    .i_q          (q_in),
    .o_bitslip    (bitslip),
    .o_locked     (locked),
    .o_error      (error),
    .o_slip_cnt   (slip_cnt),
    .o_data       (data_out),
    .o_data_valid (data_valid)
  );

  always #5 clk = ~clk;

  // Deserializer model: each slip rotates left by one, visible two cycles after the pulse.
  logic [3:0] base;
  logic       rot_clr;
  logic [1:0] rot = 2'd0;
  logic       slip_p1 = 1'b0;

  function automatic logic [3:0] rotl(input logic [3:0] w, input logic [1:0] n);
    logic [7:0] d;
    d = {w, w} << n;
    return d[7:4];
  endfunction

  always @(posedge clk) begin
    slip_p1 <= bitslip;
    if (rot_clr) rot <= 2'd0;
    else if (slip_p1) rot <= rot + 2'd1;
  end

  always_comb q_in = rotl(base, rot);

  // BITSLIP pulse monitor
  int  cyc = 0;
  int  npulse = 0;
  int  nwide = 0;
  int  last_pulse = 0;
  int  min_gap = 999;
  logic prev_bs = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bitslip) begin
      if (prev_bs) nwide = nwide + 1;
      else begin
        if (npulse > 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
        npulse = npulse + 1;
        last_pulse = cyc;
      end
    end
    prev_bs = bitslip;
  end

  task automatic clear_mon();
    npulse  = 0;
    nwide   = 0;
    min_gap = 999;
    prev_bs = bitslip;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_word(input logic [3:0] w);
    base    = w;
    rot_clr = 1'b1;
    tick();
    rot_clr = 1'b0;
  endtask

  // Caller raises TRAIN_EN just before this; LOCKED must appear on the fifth edge.
  task automatic expect_lock_in_5(input string tag);
    repeat (4) tick();
    check({tag, "_locked_early"}, {31'd0, locked}, 32'd0);
    tick();
    check({tag, "_locked_at_5"}, {31'd0, locked}, 32'd1);
  endtask

  task automatic wait_status(input bit want_err, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((want_err ? error : locked) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0] q;
    logic [3:0] exp_data;
    logic       exp_valid;
  } vec_t;

  vec_t tbl[10];
  vec_t sb[$];
  vec_t e;
  bit   ok;

  initial begin
    tbl[0] = '{4'b0011, 4'b0011, 1'b1};
    tbl[1] = '{4'b1010, 4'b1010, 1'b1};
    tbl[2] = '{4'b0101, 4'b0101, 1'b1};
    tbl[3] = '{4'b1111, 4'b1111, 1'b1};
    tbl[4] = '{4'b0000, 4'b0000, 1'b1};
    tbl[5] = '{4'b0011, 4'b0011, 1'b1};
    tbl[6] = '{4'b0110, 4'b0110, 1'b1};
    tbl[7] = '{4'b1100, 4'b1100, 1'b1};
    tbl[8] = '{4'b0111, 4'b0111, 1'b1};
    tbl[9] = '{4'b1001, 4'b1001, 1'b1};

    rst_n    = 1'b0;
    train_en = 1'b0;
    base     = 4'b0011;
    rot_clr  = 1'b1;
    repeat (3) tick();
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_bitslip", {31'd0, bitslip}, 32'd0);
    check("rst_slip_cnt", {28'd0, slip_cnt}, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_data", {28'd0, data_out}, 32'd0);
    rst_n   = 1'b1;
    rot_clr = 1'b0;
    tick();

    // Already aligned
    clear_mon();
    train_en = 1'b1;
    expect_lock_in_5("aligned");
    check("aligned_pulses", npulse, 0);
    check("aligned_slip_cnt", {28'd0, slip_cnt}, 32'd0);
    tick();
    check("aligned_valid", {31'd0, data_valid}, 32'd1);
    check("aligned_data", {28'd0, data_out}, 32'h3);

    // Data path through the scoreboard; TRAIN_EN low keeps the monitor idle
    train_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      base = tbl[i].q;
      sb.push_back(tbl[i]);
      tick();
      e = sb.pop_front();
      check($sformatf("vec%0d_data", i), {28'd0, data_out}, {28'd0, e.exp_data});
      check($sformatf("vec%0d_valid", i), {31'd0, data_valid}, {31'd0, e.exp_valid});
    end

    // Asynchronous reset while locked
    check("pre_reset_locked", {31'd0, locked}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_locked", {31'd0, locked}, 32'd0);
    check("async_rst_valid", {31'd0, data_valid}, 32'd0);
    check("async_rst_data", {28'd0, data_out}, 32'd0);
    tick();
    rst_n = 1'b1;
    set_word(4'b0011);
    train_en = 1'b1;
    expect_lock_in_5("relock");

    // Two slips needed
    set_word(4'b1100);
    train_en = 1'b0;
    tick();
    clear_mon();
    train_en = 1'b1;
    wait_status(1'b0, 80, ok);
    check("offset_lock_reached", {31'd0, ok}, 32'd1);
    check("offset_pulses", npulse, 2);
    check("offset_wide", nwide, 0);
    check("offset_gap_ok", {31'd0, min_gap >= 5}, 32'd1);
    check("offset_slip_cnt", {28'd0, slip_cnt}, 32'd2);
    tick();
    check("offset_valid", {31'd0, data_valid}, 32'd1);
    check("offset_data", {28'd0, data_out}, 32'h3);

    // Pattern never appears
    set_word(4'b0000);
    train_en = 1'b0;
    tick();
    clear_mon();
    train_en = 1'b1;
    wait_status(1'b1, 150, ok);
    check("nopat_error_reached", {31'd0, ok}, 32'd1);
    check("nopat_pulses", npulse, 8);
    check("nopat_wide", nwide, 0);
    check("nopat_gap_ok", {31'd0, min_gap >= 5}, 32'd1);
    check("nopat_locked", {31'd0, locked}, 32'd0);
    check("nopat_slip_cnt", {28'd0, slip_cnt}, 32'd8);
    repeat (10) tick();
    check("nopat_no_more_pulses", npulse, 8);
    check("nopat_error_held", {31'd0, error}, 32'd1);

    // Retrain clears ERROR, then abort during WAIT
    train_en = 1'b0;
    tick();
    train_en = 1'b1;
    tick();
    check("retrain_error_clr", {31'd0, error}, 32'd0);
    check("retrain_slip_clr", {28'd0, slip_cnt}, 32'd0);
    tick();
    check("retrain_bitslip", {31'd0, bitslip}, 32'd1);
    tick();
    train_en = 1'b0;
    clear_mon();
    tick();
    check("abort_bitslip", {31'd0, bitslip}, 32'd0);
    repeat (20) tick();
    check("abort_pulses", npulse, 0);
    check("abort_locked", {31'd0, locked}, 32'd0);
    check("abort_error", {31'd0, error}, 32'd0);
    check("abort_slip_held", {28'd0, slip_cnt}, 32'd1);

    // Lock-loss behaviour with TRAIN_EN held high
    set_word(4'b0011);
    train_en = 1'b1;
    wait_status(1'b0, 20, ok);
    check("mon_lock_reached", {31'd0, ok}, 32'd1);
    base = 4'b0000;
    repeat (7) tick();
    check("mon_7_miss", {31'd0, locked}, 32'd1);
    base = 4'b0011;
    tick();
    check("mon_match_reset", {31'd0, locked}, 32'd1);
    base = 4'b0000;
    repeat (7) tick();
    check("mon_7_miss_again", {31'd0, locked}, 32'd1);
    clear_mon();
    tick();
`ifdef ISERDES_ALIGN_MONITOR_EN
    check("mon_8_miss_drop", {31'd0, locked}, 32'd0);
    check("mon_slip_cleared", {28'd0, slip_cnt}, 32'd0);
    repeat (20) tick();
    check("mon_realign_slips", {31'd0, npulse > 0}, 32'd1);
`else
    check("nomon_8_miss_kept", {31'd0, locked}, 32'd1);
    repeat (20) tick();
    check("nomon_sticky", {31'd0, locked}, 32'd1);
    check("nomon_no_slips", npulse, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
